pll_reset_sequencer: RTL

- Supervises the system PLL (50 MHz reference in; 48/24/6 MHz out) from the reference clock domain.
- Pulses the PLL reset, waits for a lock that stays stable, then releases the core reset.
- Re-sequences on lock loss or on request.
- Declares a fault after repeated lock timeouts so the top level can report it.

---
 rtl/pll_reset_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a stable lock, then releases the core reset.
// Retries on lock timeout and latches a fault after too many failed attempts.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_FILTER_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   input  logic                               restart_req,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               ready,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
   output logic [7:0]                         lost_cnt
);

   localparam int PW = $clog2(PLL_RST_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [PW-1:0] PRST_LAST = PW'(PLL_RST_CYCLES - 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PRST,
      S_WAIT_LOCK,
      S_FILTER,
      S_RUN,
      S_FAULT
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] prst_cnt, prst_cnt_n;
   logic [FW-1:0] filt_cnt, filt_cnt_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic [RW-1:0] retry_n, retry_inc;
   logic [7:0]    lost_n;
   logic [1:0]    sync_q;
   logic          lk;

   // pll_locked comes from the PLL's own domain; two flops before any decision uses it.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   assign lk        = sync_q[1];
   assign retry_inc = retry_cnt + RW'(1);

   // Next-state and counter logic. A timeout outranks everything else in WAIT_LOCK/FILTER,
   // so an attempt that runs out of time is always charged to retry_cnt.
   always_comb begin
      state_n    = state;
      prst_cnt_n = prst_cnt;
      filt_cnt_n = filt_cnt;
      tmo_cnt_n  = tmo_cnt;
      retry_n    = retry_cnt;
      lost_n     = lost_cnt;
      case (state)
         S_PRST: begin
            if (prst_cnt == PRST_LAST) begin
               state_n   = S_WAIT_LOCK;
               tmo_cnt_n = '0;
            end else begin
               prst_cnt_n = prst_cnt + PW'(1);
            end
         end
         S_WAIT_LOCK, S_FILTER: begin
            if (tmo_cnt == TMO_LAST) begin
               retry_n = retry_inc;
               if (retry_inc == RETRY_MAX) begin
                  state_n = S_FAULT;
               end else begin
                  state_n    = S_PRST;
                  prst_cnt_n = '0;
               end
            end else if (restart_req) begin
               state_n    = S_PRST;
               prst_cnt_n = '0;
            end else begin
               tmo_cnt_n = tmo_cnt + TW'(1);
               if (state == S_WAIT_LOCK) begin
                  if (lk) begin
                     state_n    = S_FILTER;
                     filt_cnt_n = '0;
                  end
               end else if (!lk) begin
                  state_n    = S_WAIT_LOCK;
                  filt_cnt_n = '0;
               end else if (filt_cnt == FILT_LAST) begin
                  state_n = S_RUN;
                  retry_n = '0;
               end else begin
                  filt_cnt_n = filt_cnt + FW'(1);
               end
            end
         end
         S_RUN: begin
            if (!lk) begin
               state_n    = S_PRST;
               prst_cnt_n = '0;
               if (lost_cnt != 8'hFF) begin
                  lost_n = lost_cnt + 8'd1;
               end
            end else if (restart_req) begin
               state_n    = S_PRST;
               prst_cnt_n = '0;
            end
         end
         S_FAULT: begin
            if (restart_req) begin
               state_n    = S_PRST;
               prst_cnt_n = '0;
               retry_n    = '0;
            end
         end
         default: begin
            state_n    = S_PRST;
            prst_cnt_n = '0;
         end
      endcase
   end

   // State, counters and outputs share one register stage; outputs decode the next state
   // so they switch on the same edge as the state itself.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= S_PRST;
         prst_cnt  <= '0;
         filt_cnt  <= '0;
         tmo_cnt   <= '0;
         retry_cnt <= '0;
         lost_cnt  <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         prst_cnt  <= prst_cnt_n;
         filt_cnt  <= filt_cnt_n;
         tmo_cnt   <= tmo_cnt_n;
         retry_cnt <= retry_n;
         lost_cnt  <= lost_n;
         pll_rst   <= (state_n == S_PRST) || (state_n == S_FAULT);
         sys_rst   <= (state_n != S_RUN);
         ready     <= (state_n == S_RUN);
         fault     <= (state_n == S_FAULT);
      end
   end

endmodule
